// File: rtl/vga_pixel_sink_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel sink: 640x480@60 timing constants
// (in pixel-clock units), framebuffer geometry, the colour type, the bundle
// of raw sync/blank controls and the framebuffer address helper.
// ----------------------------------------------------------------------------
package vga_pkg;

    // Scan counters are 10 bits wide (h 0..799, v 0..524).
    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_VISIBLE    = 10'd640;
    localparam cnt_t H_FP         = 10'd16;
    localparam cnt_t H_SYNC       = 10'd96;
    localparam cnt_t H_BP         = 10'd48;
    localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam cnt_t H_TOTAL      = H_SYNC_END + H_BP;

    localparam cnt_t V_VISIBLE    = 10'd480;
    localparam cnt_t V_FP         = 10'd10;
    localparam cnt_t V_SYNC       = 10'd2;
    localparam cnt_t V_BP         = 10'd33;
    localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam cnt_t V_TOTAL      = V_SYNC_END + V_BP;

    // Framebuffer: 160x120 entries of {R,G,B}.
    localparam int FB_ADDR_W = 15;
    localparam int FB_DEPTH  = 160 * 120;
    localparam int COLOUR_W  = 3;

    typedef logic [COLOUR_W-1:0] colour_t;

    // Raw (unregistered) scan controls, all active-low.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    // Linear framebuffer address y*160 + x, with the multiply expressed as
    // (y<<7)+(y<<5). Callers zero-extend x and y to the address width.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_ADDR_W-1:0] x,
                                                     input logic [FB_ADDR_W-1:0] y);
        return (y << 7) + (y << 5) + x;
    endfunction

endpackage

// File: rtl/vga_pixel_sink_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Generates the 25 MHz pixel enable from the 50 MHz clock and runs the
// 800x525 horizontal/vertical scan counters, decoding raw sync and blank.
//
// Ports:
//   clk           in   50 MHz system clock
//   reset         in   synchronous, active-low
//   o_pix_en      out  toggles every clk; counters advance when it is 1
//   o_h_cnt       out  horizontal position 0..799
//   o_v_cnt       out  vertical position 0..524
//   o_ctl         out  combinational hs_n / vs_n / blank_n for current counts
//   o_frame_start out  one-clk pulse when the scan enters line 480, pixel 0
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    output logic     o_pix_en,
    output cnt_t     o_h_cnt,
    output cnt_t     o_v_cnt,
    output vga_ctl_t o_ctl,
    output logic     o_frame_start
);

    logic     r_pix_en;
    cnt_t     r_h_cnt;
    cnt_t     r_v_cnt;
    logic     r_frame_start;
    vga_ctl_t w_ctl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix_en      <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= !r_pix_en;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                if (r_h_cnt == H_TOTAL - 10'd1) begin
                    r_h_cnt <= '0;
                    if (r_v_cnt == V_TOTAL - 10'd1) begin
                        r_v_cnt <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 10'd1;
                    end
                    // Goes high in the same clk the counters show (0,480).
                    if (r_v_cnt == V_VISIBLE - 10'd1) begin
                        r_frame_start <= 1'b1;
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        w_ctl         = CTL_IDLE;
        w_ctl.hs_n    = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
        w_ctl.vs_n    = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
        w_ctl.blank_n = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);
    end

    assign o_pix_en      = r_pix_en;
    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_ctl         = w_ctl;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_pixel_sink.sv
// ----------------------------------------------------------------------------
// vga_pixel_sink
// Receives plot strobes (x, y, colour) into a 160x120x3 framebuffer and scans
// it out as 640x480@60 VGA with 4x pixel replication. Out-of-bounds plots are
// dropped and reported through a sticky flag and a saturating counter.
//
// Ports:
//   clk          in   50 MHz system clock
//   reset        in   synchronous, active-low
//   plot         in   write strobe, one pixel per clk while high
//   x, y         in   framebuffer column (8b) / row (7b)
//   colour       in   pixel colour {R,G,B}
//   oob_clr      in   clears oob_err / oob_count (a same-cycle drop wins)
//   oob_err      out  sticky out-of-bounds flag
//   oob_count    out  saturating dropped-plot count
//   frame_start  out  one-clk pulse at start of vertical blank
//   vga_r/g/b    out  8-bit channels, zero while blanked
//   vga_hs/vs    out  active-low syncs
//   vga_blank_n  out  low outside the visible region
//   vga_clk      out  25 MHz pixel clock (registered pixel enable)
//
// Optional build macro VGA_PIXEL_SINK_READBACK_EN adds a third memory port:
//   rd_x, rd_y   in   readback coordinates
//   rd_colour    out  mem[rd_y*160+rd_x] one clk later, 0 when out of range
// ----------------------------------------------------------------------------
module vga_pixel_sink
    import vga_pkg::*;
#(
    parameter int X_PIXELS    = 160,
    parameter int Y_PIXELS    = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int OOB_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 plot,
    input  logic [7:0]           x,
    input  logic [6:0]           y,
    input  logic [COLOUR_W-1:0]  colour,
    input  logic                 oob_clr,
    output logic                 oob_err,
    output logic [OOB_CNT_W-1:0] oob_count,
    output logic                 frame_start,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic                 vga_clk
`ifdef VGA_PIXEL_SINK_READBACK_EN
    ,
    input  logic [7:0]           rd_x,
    input  logic [6:0]           rd_y,
    output logic [COLOUR_W-1:0]  rd_colour
`endif
);

    localparam logic [OOB_CNT_W-1:0] OOB_ONE = 1;
    localparam logic [OOB_CNT_W-1:0] OOB_MAX = '1;

    // Expands a 3-bit colour to 24-bit RGB, forcing black outside the
    // visible window.
    function automatic logic [23:0] expand_rgb(input colour_t c, input logic vis);
        return vis ? {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}} : 24'h0;
    endfunction

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic     w_pix_en;
    cnt_t     w_h_cnt;
    cnt_t     w_v_cnt;
    vga_ctl_t w_ctl;
    logic     w_frame_start;

    vga_timing_gen u_timing (
        .clk           (clk),
        .reset         (reset),
        .o_pix_en      (w_pix_en),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_ctl         (w_ctl),
        .o_frame_start (w_frame_start)
    );

    // ------------------------------------------------------------------
    // Write path and out-of-bounds detection
    // ------------------------------------------------------------------
    logic                 w_in_range;
    logic                 w_we;
    logic                 w_oob;
    logic [FB_ADDR_W-1:0] w_wr_addr;
    logic [FB_ADDR_W-1:0] w_scan_addr;

    assign w_in_range = (x < 8'(X_PIXELS)) && (y < 7'(Y_PIXELS));
    // A plot presented while reset is held is discarded entirely.
    assign w_we       = reset && plot && w_in_range;
    assign w_oob      = plot && !w_in_range;
    assign w_wr_addr  = w_in_range ? fb_addr(FB_ADDR_W'(x), FB_ADDR_W'(y)) : '0;

    // Outside the visible window the shifted counters exceed the framebuffer,
    // so the read address is parked at 0 there.
    assign w_scan_addr = w_ctl.blank_n
                       ? fb_addr(FB_ADDR_W'(w_h_cnt >> SCALE_SHIFT),
                                 FB_ADDR_W'(w_v_cnt >> SCALE_SHIFT))
                       : '0;

    logic [OOB_CNT_W-1:0] r_oob_count;
    logic                 r_oob_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_oob_err   <= 1'b0;
            r_oob_count <= '0;
        end else if (w_oob) begin
            r_oob_err <= 1'b1;
            // A drop in the same cycle as a clear restarts the count at 1.
            if (oob_clr) begin
                r_oob_count <= OOB_ONE;
            end else if (r_oob_count != OOB_MAX) begin
                r_oob_count <= r_oob_count + OOB_ONE;
            end
        end else if (oob_clr) begin
            r_oob_err   <= 1'b0;
            r_oob_count <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Framebuffer: one write port, registered read ports. Non-blocking
    // reads give read-first behaviour on a same-address collision.
    // ------------------------------------------------------------------
    colour_t r_mem [FB_DEPTH];
    colour_t r_rd_colour_p1;

`ifdef VGA_PIXEL_SINK_READBACK_EN
    logic                 w_rb_ok;
    logic [FB_ADDR_W-1:0] w_rb_addr;
    logic                 r_rb_ok_p1;
    colour_t              r_rb_colour_p1;

    assign w_rb_ok   = (rd_x < 8'(X_PIXELS)) && (rd_y < 7'(Y_PIXELS));
    assign w_rb_addr = w_rb_ok ? fb_addr(FB_ADDR_W'(rd_x), FB_ADDR_W'(rd_y)) : '0;
`endif

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wr_addr] <= colour;
        end
        r_rd_colour_p1 <= r_mem[w_scan_addr];
`ifdef VGA_PIXEL_SINK_READBACK_EN
        r_rb_colour_p1 <= r_mem[w_rb_addr];
        r_rb_ok_p1     <= w_rb_ok;
`endif
    end

`ifdef VGA_PIXEL_SINK_READBACK_EN
    assign rd_colour = r_rb_ok_p1 ? r_rb_colour_p1 : '0;
`endif

    // ------------------------------------------------------------------
    // Stage p1: controls delayed to match the framebuffer read latency
    // ------------------------------------------------------------------
    vga_ctl_t r_ctl_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctl_p1 <= CTL_IDLE;
        end else begin
            r_ctl_p1 <= w_ctl;
        end
    end

    // ------------------------------------------------------------------
    // Stage p2: output registers driving the pins
    // ------------------------------------------------------------------
    logic        r_hs_p2;
    logic        r_vs_p2;
    logic        r_blank_n_p2;
    logic [23:0] r_rgb_p2;
    logic        r_vga_clk_p2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hs_p2      <= 1'b1;
            r_vs_p2      <= 1'b1;
            r_blank_n_p2 <= 1'b0;
            r_rgb_p2     <= '0;
            r_vga_clk_p2 <= 1'b0;
        end else begin
            r_hs_p2      <= r_ctl_p1.hs_n;
            r_vs_p2      <= r_ctl_p1.vs_n;
            r_blank_n_p2 <= r_ctl_p1.blank_n;
            r_rgb_p2     <= expand_rgb(r_rd_colour_p1, r_ctl_p1.blank_n);
            r_vga_clk_p2 <= w_pix_en;
        end
    end

    assign vga_r       = r_rgb_p2[23:16];
    assign vga_g       = r_rgb_p2[15:8];
    assign vga_b       = r_rgb_p2[7:0];
    assign vga_hs      = r_hs_p2;
    assign vga_vs      = r_vs_p2;
    assign vga_blank_n = r_blank_n_p2;
    assign vga_clk     = r_vga_clk_p2;
    assign frame_start = w_frame_start;
    assign oob_err     = r_oob_err;
    assign oob_count   = r_oob_count;

endmodule
